// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler that shares one LSB-first PISO between two
// valid/ready word requesters and emits bit-timing qualifiers for the serial stream.
module piso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             piso_load,
    output logic             piso_shift,
    output logic [WIDTH-1:0] piso_pin,
    output logic             bit_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             owner,
    output logic             busy
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          shift_q, shift_d;
    logic          bit_valid_q, bit_valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          idle_s;
    logic          grant0_s;
    logic          grant1_s;

    // Arbitration: reset is folded in so ready/load stay low while rst_n is asserted
    always_comb begin
        idle_s   = rst_n && (state_q == ST_IDLE);
        grant0_s = idle_s && req0_valid && (!req1_valid || !prio_q);
        grant1_s = idle_s && req1_valid && (!req0_valid || prio_q);
    end

    // Handshake and PISO load path, combinational in the grant cycle
    always_comb begin
        req0_ready = grant0_s;
        req1_ready = grant1_s;
        piso_load  = grant0_s | grant1_s;
        if (grant0_s) begin
            piso_pin = req0_data;
        end else if (grant1_s) begin
            piso_pin = req1_data;
        end else begin
            piso_pin = {WIDTH{1'b0}};
        end
    end

    // Next-state, counters and next values of the registered qualifiers
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = {BW{1'b0}};
                    div_cnt_d = {DW{1'b0}};
                    owner_d   = grant1_s;
                    prio_d    = ~grant1_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = {DW{1'b0}};
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end else if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = {GW{1'b0}};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Qualifiers are computed from the next state so they register cleanly
        bit_valid_d = (state_d == ST_SHIFT);
        shift_d     = bit_valid_d && (div_cnt_d == DIV_LAST) && (bit_cnt_d != BIT_LAST);
        first_d     = bit_valid_d && (bit_cnt_d == {BW{1'b0}});
        last_d      = bit_valid_d && (bit_cnt_d == BIT_LAST);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers, cleared immediately by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {BW{1'b0}};
            div_cnt_q   <= {DW{1'b0}};
            gap_cnt_q   <= {GW{1'b0}};
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            shift_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            shift_q     <= shift_d;
            bit_valid_q <= bit_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign piso_shift  = shift_q;
    assign bit_valid   = bit_valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;
    assign owner       = owner_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: three instances (DIV/GAP = 1/1, 3/0, 1/0) share the
// requester inputs; each drives its own behavioural PISO model.
module tb_piso_tx_sched;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;

    logic         a_r0, a_r1, a_ld, a_sh, a_bv, a_ff, a_fl, a_own, a_busy;
    logic         b_r0, b_r1, b_ld, b_sh, b_bv, b_ff, b_fl, b_own, b_busy;
    logic         c_r0, c_r1, c_ld, c_sh, c_bv, c_ff, c_fl, c_own, c_busy;
    logic [W-1:0] a_pin, b_pin, c_pin;
    logic [W-1:0] a_sr, b_sr, c_sr;

    int checks   = 0;
    int failures = 0;

    piso_tx_sched #(.WIDTH(W), .DIV(1), .GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
        .piso_load(a_ld), .piso_shift(a_sh), .piso_pin(a_pin),
        .bit_valid(a_bv), .frame_first(a_ff), .frame_last(a_fl),
        .owner(a_own), .busy(a_busy)
    );

    piso_tx_sched #(.WIDTH(W), .DIV(3), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
        .piso_load(b_ld), .piso_shift(b_sh), .piso_pin(b_pin),
        .bit_valid(b_bv), .frame_first(b_ff), .frame_last(b_fl),
        .owner(b_own), .busy(b_busy)
    );

    piso_tx_sched #(.WIDTH(W), .DIV(1), .GAP(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(c_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(c_r1),
        .piso_load(c_ld), .piso_shift(c_sh), .piso_pin(c_pin),
        .bit_valid(c_bv), .frame_first(c_ff), .frame_last(c_fl),
        .owner(c_own), .busy(c_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PISO models: load wins over shift, serial output is bit 0
    always @(posedge clk) begin
        if (a_ld) a_sr <= a_pin; else if (a_sh) a_sr <= {1'b0, a_sr[W-1:1]};
        if (b_ld) b_sr <= b_pin; else if (b_sh) b_sr <= {1'b0, b_sr[W-1:1]};
        if (c_ld) c_sr <= c_pin; else if (c_sh) c_sr <= {1'b0, c_sr[W-1:1]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'hA;
        req1_data  = 4'h5;
        step();
        step();
        sample();
        checks++;
        if ({a_r0, a_r1, b_r0, b_r1, c_r0, c_r1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 000000", {a_r0, a_r1, b_r0, b_r1, c_r0, c_r1});
        end
        checks++;
        if ({a_ld, a_sh, a_bv, a_ff, a_fl, a_own, a_busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000000", {a_ld, a_sh, a_bv, a_ff, a_fl, a_own, a_busy});
        end
        checks++;
        if ({a_pin, b_pin, c_pin} !== 12'h000) begin
            failures++;
            $display("FAIL reset_pin: got %h expected 000", {a_pin, b_pin, c_pin});
        end
        checks++;
        if ({b_ld, b_bv, b_busy, c_ld, c_bv, c_busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_other: got %b expected 000000", {b_ld, b_bv, b_busy, c_ld, c_bv, c_busy});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            checks++;
            if ({a_busy, b_busy, c_busy, a_ld, a_bv} !== 5'b0) begin
                failures++;
                $display("FAIL idle_after_reset: cycle %0d got %b expected 00000", i, {a_busy, b_busy, c_busy, a_ld, a_bv});
            end
            step();
        end
    endtask

    task automatic test_single_word();
        logic exp_bits[$];
        logic eb;
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 4'b1011;
        sample();
        checks++;
        if ({a_r0, a_r1, a_ld, a_pin} !== {1'b1, 1'b0, 1'b1, 4'b1011}) begin
            failures++;
            $display("FAIL single_load: got r0=%b r1=%b ld=%b pin=%b expected 1 0 1 1011", a_r0, a_r1, a_ld, a_pin);
        end
        for (int k = 0; k < W; k++) exp_bits.push_back(req0_data[k]);
        step();
        req0_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            sample();
            eb = exp_bits.pop_front();
            checks++;
            if ({a_sr[0], a_bv, a_sh, a_ff, a_fl, a_own, a_ld} !==
                {eb, 1'b1, (k < W - 1), (k == 0), (k == W - 1), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL single_bit%0d: got ser/bv/sh/ff/fl/own/ld=%b expected %b", k,
                         {a_sr[0], a_bv, a_sh, a_ff, a_fl, a_own, a_ld},
                         {eb, 1'b1, (k < W - 1), (k == 0), (k == W - 1), 1'b0, 1'b0});
            end
            step();
        end
        sample();
        checks++;
        if ({a_bv, a_busy, a_sh, a_ld} !== 4'b0100) begin
            failures++;
            $display("FAIL single_gap: got bv/busy/sh/ld=%b expected 0100", {a_bv, a_busy, a_sh, a_ld});
        end
        step();
        req0_valid = 1'b1;
        req0_data  = 4'b0110;
        sample();
        checks++;
        if ({a_ld, a_r0, a_busy, a_pin} !== {1'b1, 1'b1, 1'b0, 4'b0110}) begin
            failures++;
            $display("FAIL single_reload: got ld/r0/busy=%b pin=%b expected 110 0110", {a_ld, a_r0, a_busy}, a_pin);
        end
        step();
        req0_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [W:0] sb[$];
        logic [W:0] cur;
        logic       exp_gnt;
        logic       r0s, r1s;
        int         words, cyc, bi;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'h3;
        req1_data  = 4'hC;
        exp_gnt    = 1'b0;
        words      = 0;
        cyc        = 0;
        bi         = 0;
        cur        = '0;
        while (words < 6 && cyc < 200) begin
            sample();
            r0s = a_r0;
            r1s = a_r1;
            checks++;
            if ((a_r0 | a_r1) !== a_ld) begin
                failures++;
                $display("FAIL cont_ready_vs_load: got ready=%b%b load=%b", a_r1, a_r0, a_ld);
            end
            if (a_ld) begin
                checks++;
                if ({a_r1, a_r0} !== (exp_gnt ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL cont_grant: got r1r0=%b expected requester %0d", {a_r1, a_r0}, exp_gnt);
                end
                sb.push_back({exp_gnt, exp_gnt ? req1_data : req0_data});
                exp_gnt = ~exp_gnt;
            end
            if (a_bv) begin
                if (a_ff) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL cont_unexpected_frame: got frame expected none");
                    end else begin
                        cur = sb.pop_front();
                    end
                    bi = 0;
                end
                if (bi < W) begin
                    checks++;
                    if ({a_sr[0], a_own} !== {cur[bi], cur[W]}) begin
                        failures++;
                        $display("FAIL cont_bit: word %0d bit %0d got ser/own=%b expected %b", words, bi,
                                 {a_sr[0], a_own}, {cur[bi], cur[W]});
                    end
                end
                if (a_fl) words++;
                bi++;
            end
            step();
            if (r0s) req0_data = req0_data + 4'd3;
            if (r1s) req1_data = req1_data + 4'd5;
            cyc++;
        end
        checks++;
        if (words < 6) begin
            failures++;
            $display("FAIL cont_timeout: got %0d words expected 6", words);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_bit_hold();
        logic [W-1:0] wq[$];
        logic [W-1:0] cur;
        logic         r1s;
        int           cyc, last, loads, off, k;
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 4'b1001;
        cyc   = 0;
        last  = -1;
        loads = 0;
        cur   = '0;
        while (loads < 3 && cyc < 80) begin
            sample();
            r1s = b_r1;
            if (b_ld) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 13) begin
                        failures++;
                        $display("FAIL hold_spacing: got %0d expected 13", cyc - last);
                    end
                end
                checks++;
                if (b_bv !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_bv_in_load: got %b expected 0", b_bv);
                end
                wq.push_back(req1_data);
                last = cyc;
                loads++;
            end else if (last >= 0) begin
                off = cyc - last;
                k   = (off - 1) / 3;
                if (off == 1) begin
                    if (wq.size() > 0) cur = wq.pop_front();
                end
                checks++;
                if ({b_bv, b_sr[0], b_sh, b_ff, b_fl, b_own} !==
                    {1'b1, cur[k], ((off % 3 == 0) && (k < W - 1)), (k == 0), (k == W - 1), 1'b1}) begin
                    failures++;
                    $display("FAIL hold_bit: offset %0d got bv/ser/sh/ff/fl/own=%b expected %b", off,
                             {b_bv, b_sr[0], b_sh, b_ff, b_fl, b_own},
                             {1'b1, cur[k], ((off % 3 == 0) && (k < W - 1)), (k == 0), (k == W - 1), 1'b1});
                end
            end
            step();
            if (r1s) req1_data = req1_data + 4'd7;
            cyc++;
        end
        checks++;
        if (loads < 3) begin
            failures++;
            $display("FAIL hold_timeout: got %0d loads expected 3", loads);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wq[$];
        logic [W-1:0] cur;
        logic         r1s;
        int           cyc, last, loads, k;
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 4'b0011;
        cyc   = 0;
        last  = -1;
        loads = 0;
        cur   = '0;
        while (loads < 4 && cyc < 60) begin
            sample();
            r1s = c_r1;
            if (c_ld) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 5) begin
                        failures++;
                        $display("FAIL b2b_spacing: got %0d expected 5", cyc - last);
                    end
                end
                checks++;
                if ({c_bv, c_r1} !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_load_cycle: got bv/r1=%b expected 01", {c_bv, c_r1});
                end
                wq.push_back(req1_data);
                last = cyc;
                loads++;
            end else if (last >= 0) begin
                k = cyc - last - 1;
                if (k == 0) begin
                    if (wq.size() > 0) cur = wq.pop_front();
                end
                checks++;
                if ({c_bv, c_sr[0], c_sh, c_ff, c_fl, c_own} !==
                    {1'b1, cur[k], (k < W - 1), (k == 0), (k == W - 1), 1'b1}) begin
                    failures++;
                    $display("FAIL b2b_bit: bit %0d got bv/ser/sh/ff/fl/own=%b expected %b", k,
                             {c_bv, c_sr[0], c_sh, c_ff, c_fl, c_own},
                             {1'b1, cur[k], (k < W - 1), (k == 0), (k == W - 1), 1'b1});
                end
            end
            step();
            if (r1s) req1_data = req1_data + 4'd6;
            cyc++;
        end
        checks++;
        if (loads < 4) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d loads expected 4", loads);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 4'b0101;
        sample();
        checks++;
        if ({a_r1, a_ld} !== 2'b11) begin
            failures++;
            $display("FAIL mid_load: got r1/ld=%b expected 11", {a_r1, a_ld});
        end
        step();
        req1_valid = 1'b0;
        sample();
        step();
        sample();
        step();
        #2;
        checks++;
        if ({a_bv, a_own, a_sh, a_sr[0]} !== 4'b1111) begin
            failures++;
            $display("FAIL mid_bit2: got bv/own/sh/ser=%b expected 1111", {a_bv, a_own, a_sh, a_sr[0]});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_bv, a_sh, a_ff, a_fl, a_own, a_busy, a_ld, a_r0, a_r1, a_pin} !== 13'b0) begin
            failures++;
            $display("FAIL mid_async_clear: got %b expected all zero",
                     {a_bv, a_sh, a_ff, a_fl, a_own, a_busy, a_ld, a_r0, a_r1, a_pin});
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'hE;
        req1_data  = 4'h7;
        step();
        rst_n = 1'b1;
        sample();
        checks++;
        if ({a_r0, a_r1, a_ld, a_pin} !== {1'b1, 1'b0, 1'b1, 4'hE}) begin
            failures++;
            $display("FAIL mid_regrant: got r0/r1/ld=%b pin=%h expected 101 e", {a_r0, a_r1, a_ld}, a_pin);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_single_word();
        test_contention();
        test_bit_hold();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_tx_sched.md
# piso_tx_sched

Round-robin scheduler and sequencer that shares one parallel-in serial-out shift register (PISO, `WIDTH` bits, LSB first, load has priority over shift) between two parallel-word requesters. It accepts one word at a time through a valid/ready handshake and drives the PISO's `load`, `shift_right` and `pin` controls. It also produces bit-timing qualifiers (`bit_valid`, `frame_first`, `frame_last`, `owner`) for downstream consumers of the PISO serial output. It sits between the word producers and the PISO instance in the transmit path.

## Interface
- `WIDTH`, default 4: word width. Must match the PISO width. `WIDTH >= 2`.
- `DIV`, default 1: clock cycles each serial bit is held. `DIV >= 1`.
- `GAP`, default 1: idle cycles inserted after each word. `GAP >= 0`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: requester 0 offers a word.
- `req0_data` in `WIDTH`: requester 0 word.
- `req0_ready` out 1: requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `piso_load` out 1: to the PISO `load` input.
- `piso_shift` out 1: to the PISO `shift_right` input.
- `piso_pin` out `WIDTH`: to the PISO `pin` input.
- `bit_valid` out 1: the PISO serial output currently carries a valid bit.
- `frame_first` out 1: the current bit is bit 0 of a word.
- `frame_last` out 1: the current bit is bit `WIDTH-1` of a word.
- `owner` out 1: requester id of the word being serialized. Meaningful only while `bit_valid` = 1.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, SHIFT, GAP. The reset state is IDLE.
- **Round-robin priority:** a 1-bit priority pointer `prio` selects the favoured requester. Reset value is 0 (requester 0 favoured).
- **IDLE:**
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester selected by `prio`.
  - On a grant, in the same cycle:
    - Assert the granted `reqX_ready` (combinational from state and valids).
    - Assert `piso_load` = 1.
    - Drive `piso_pin` = granted data.
    - Set `prio` to the other requester.
    - Register `owner` = granted id.
    - Go to SHIFT.
  - With no request: hold IDLE. `piso_load` = 0 and `piso_pin` = 0.
- **Handshake rules:**
  - A transfer occurs only when `valid` and `ready` are both 1.
  - `ready` may depend combinationally on `valid`. `valid` must not depend on `ready`.
  - Data is sampled only in the transfer cycle.
  - `ready` is never asserted outside IDLE, and never to both requesters in the same cycle.
- **SHIFT:**
  - `bit_cnt` (0..`WIDTH-1`) and `div_cnt` (0..`DIV-1`) are both cleared on entry.
  - `bit_valid` = 1 throughout the state.
  - On `div_cnt == DIV-1`:
    - If `bit_cnt < WIDTH-1`: assert `piso_shift` for this one cycle, increment `bit_cnt`, clear `div_cnt`.
    - If `bit_cnt == WIDTH-1`: no shift; go to GAP, or to IDLE when `GAP == 0`.
  - `frame_first` = (`bit_cnt` == 0).
  - `frame_last` = (`bit_cnt` == `WIDTH-1`).
  - `piso_load` and `piso_shift` are never asserted together.
- **GAP:** count `GAP` cycles with all strobes low, then return to IDLE.
- **Word period:** each word occupies exactly `1 + WIDTH*DIV + GAP` cycles, measured from one load to the next load when requests are back-to-back.
- **Reset mid-operation:**
  - `rst_n` low immediately forces IDLE and clears all counters, `prio` and all outputs.
  - The in-flight word is dropped, not retransmitted.
  - PISO contents are don't-care while `bit_valid` = 0.

## Timing
- **Reset values:** every output is 0 while `rst_n` = 0 (ready, load, shift, pin, bit_valid, frame_first, frame_last, owner, busy).
- **Load timing:** in load cycle L, the PISO captures `pin` at the edge ending L.
- **Bit timing:** bit k is visible on the PISO serial output during cycles `L+1+k*DIV` through `L+(k+1)*DIV`, with `bit_valid` = 1.
- **Shift timing:** `piso_shift` is high in cycle `L+(k+1)*DIV` for k = 0..`WIDTH-2`.
- **Registered outputs:** `piso_shift`, `bit_valid`, `frame_*` and `busy` are decoded from registered state only.
- **Combinational outputs:** `piso_load`, `piso_pin` and `reqX_ready` are combinational in IDLE.
- **Latency:** the first serial bit appears 1 cycle after acceptance.

## Test plan
- **Reset:** hold `rst_n` = 0 with both valids high -> all outputs 0, no ready. Release with valids low -> IDLE, `busy` = 0 indefinitely.
- **Single word** (`WIDTH`=4, `DIV`=1, `GAP`=1): req0 sends 4'b1011, load at cycle L ->
  - serial output 1,1,0,1 on L+1..L+4 with `bit_valid` = 1;
  - `piso_shift` high on L+1..L+3;
  - `frame_first` at L+1, `frame_last` at L+4;
  - idle at L+5; next load possible at L+6.
- **Contention:** both valid continuously -> grants alternate 0,1,0,1 starting with 0. `owner` matches each word. Each word is accepted exactly once.
- **Bit hold** (`DIV`=3, `GAP`=0): each bit is held 3 cycles; shift on the 3rd cycle of bits 0..2. Back-to-back load-to-load spacing is 13 cycles.
- **Back-to-back** (`DIV`=1, `GAP`=0): req1 constantly valid -> loads every 5 cycles; `bit_valid` low only in the load cycles.
- **Reset mid-shift:** assert `rst_n` low asynchronously during bit 2 of a req1 word ->
  - outputs go to 0 before the next edge;
  - after release with both valid, req0 is granted first.
